// File: rtl/lbp_image_host.sv
`timescale 1ns/1ps
// Memory-side responder for the LBP engine: serves a byte-loaded 128x128 gray image
// and captures result writes with count, border/duplicate flags and a checksum.
//
// state | meaning
// CLEAR | sweep idx over result memory, zero data and written bits
// LOAD  | accept image bytes in raster order
// SERVE | answer gray reads, capture lbp writes
// DONE  | results frozen, pass/fail reported

module lbp_image_host #(
    parameter int EXPECT_COUNT = 15876
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    input  logic        gray_req,
    input  logic [13:0] gray_addr,
    output logic        gray_ready,
    output logic [7:0]  gray_data,
    input  logic        lbp_valid,
    input  logic [13:0] lbp_addr,
    input  logic [7:0]  lbp_data,
    input  logic        finish,
    input  logic        restart,
    input  logic [13:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic [14:0] wr_count,
    output logic [21:0] checksum,
    output logic        err_border,
    output logic        err_dup,
    output logic        done,
    output logic        pass
);

    typedef enum logic [1:0] {CLEAR, LOAD, SERVE, DONE} state_t;

    state_t      state, state_next;
    logic [13:0] idx;
    logic [7:0]  img     [0:16383];
    logic [7:0]  res     [0:16383];
    logic        written [0:16383];
    logic        last_idx;
    logic        capture;
    logic        border;

    assign last_idx = (idx == 14'h3FFF);
    assign capture  = (state == SERVE) && lbp_valid;
    assign border   = (lbp_addr[13:7] == 7'd0) || (lbp_addr[13:7] == 7'd127) ||
                      (lbp_addr[6:0]  == 7'd0) || (lbp_addr[6:0]  == 7'd127);

    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        gray_ready = 1'b0;
        gray_data  = 8'd0;
        done       = 1'b0;
        case (state)
            CLEAR: begin
                if (last_idx) state_next = LOAD;
            end
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid && last_idx) state_next = SERVE;
            end
            SERVE: begin
                gray_ready = 1'b1;
                if (gray_req) gray_data = img[gray_addr];
                if (finish) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (restart) state_next = CLEAR;
            end
            default: state_next = CLEAR;
        endcase
    end

    assign pass = done && (wr_count == 15'(EXPECT_COUNT)) && !err_border && !err_dup;

    // idx is the clear sweep in CLEAR and the load address in LOAD; it wraps to 0 on exit of both
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= state_next;
            case (state)
                CLEAR:   idx <= idx + 14'd1;
                LOAD:    if (load_valid) idx <= idx + 14'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_count   <= '0;
            checksum   <= '0;
            err_border <= 1'b0;
            err_dup    <= 1'b0;
        end else if (state == CLEAR && last_idx) begin
            wr_count   <= '0;
            checksum   <= '0;
            err_border <= 1'b0;
            err_dup    <= 1'b0;
        end else if (capture) begin
            if (wr_count != 15'h7FFF) wr_count <= wr_count + 15'd1;
            checksum <= checksum + {14'd0, lbp_data};
            if (border) err_border <= 1'b1;
            if (written[lbp_addr]) err_dup <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && state == LOAD && load_valid) img[idx] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            res[idx]     <= 8'd0;
            written[idx] <= 1'b0;
        end else if (reset && capture) begin
            res[lbp_addr]     <= lbp_data;
            written[lbp_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) rd_data <= 8'd0;
        else        rd_data <= res[rd_addr];
    end

endmodule

// File: doc/lbp_image_host.md
# lbp_image_host

Memory-side responder for the LBP engine's gray-image read port and its result write port. It holds a 128x128 8-bit gray image loaded by a byte stream and serves `gray_addr` reads to the engine. It captures every `lbp_valid` write into a result memory, with counting, border and duplicate checks and a checksum. It sits opposite the LBP engine and owns `gray_ready`/`gray_data`, and it consumes `gray_req`/`gray_addr`/`lbp_*`/`finish`.

## Interface
- `EXPECT_COUNT`, default 15876: number of result writes required for `pass` (126x126 interior pixels).
- `clk` in 1: single clock, all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; sampled on the `clk` rising edge.
- `load_valid` in 1: image byte available.
- `load_data` in 8: image byte, raster order, address 0 first.
- `load_ready` out 1: host accepts a byte when `load_valid && load_ready`.
- `gray_req` in 1: engine read request.
- `gray_addr` in 14: {row[6:0], col[6:0]}.
- `gray_ready` out 1: image loaded and serving.
- `gray_data` out 8: pixel at `gray_addr`.
- `lbp_valid` in 1: result write strobe, one cycle per pixel.
- `lbp_addr` in 14: {row, col} of result.
- `lbp_data` in 8: LBP code.
- `finish` in 1: engine level signal, high when engine complete.
- `restart` in 1: one-cycle pulse, legal only in DONE.
- `rd_addr` in 14: result readout address.
- `rd_data` out 8: result memory readout.
- `wr_count` out 15: accepted result writes.
- `checksum` out 22: sum of all captured `lbp_data`, zero-extended.
- `err_border` out 1: sticky; a write landed with row or col equal to 0 or 127.
- `err_dup` out 1: sticky; a second write landed on an already-written address.
- `done` out 1: in DONE.
- `pass` out 1: `done && wr_count==EXPECT_COUNT && !err_border && !err_dup`.

## Operation
- FSM states are CLEAR, LOAD, SERVE and DONE. Reset (`reset==0` at a rising edge) forces CLEAR from any state and aborts any load or serve in progress.
- CLEAR runs an internal 14-bit index over 0..16383, one location per cycle, writing 0 to the result memory and clearing the per-address written bit.
  - Takes exactly 16384 cycles.
  - On index 16383 it clears `wr_count`, `checksum`, `err_border` and `err_dup` and moves to LOAD.
- LOAD asserts `load_ready`. Each handshake writes `load_data` to image address k (k = 0,1,...) and increments k.
  - The handshake for k=16383 moves to SERVE; no further bytes are accepted.
  - `load_valid` gaps only stall.
- SERVE asserts `gray_ready`.
  - `gray_data = mem[gray_addr]` combinationally when `gray_req==1`, otherwise 0 (same-cycle read: the engine samples data on the edge after it registers the address).
  - Consecutive requests are served every cycle with no stall.
- Result capture is active in SERVE only. On `lbp_valid` in SERVE:
  - Write `lbp_data` to the result memory at `lbp_addr`.
  - Set the written bit for that address.
  - `wr_count+1`; `checksum += lbp_data`.
  - If the address is a border address (row or col equal to 0 or 127), set `err_border`; the write still happens.
  - If the written bit was already set, set `err_dup`; the value is overwritten and the write is still counted.
- `lbp_valid` outside SERVE is ignored. In SERVE, `finish==1` moves the FSM to DONE.
- A write with `lbp_valid` in the same cycle as `finish` is captured.
- DONE:
  - `gray_ready=0` and `gray_data=0`; the result memory is frozen.
  - `done=1`; `pass` is combinational from the counters and flags.
  - `restart` moves the FSM to CLEAR. `restart` in any other state is ignored.
- `rd_data` is the registered result memory read at `rd_addr`: 1-cycle latency, usable in any state; during CLEAR it returns partially cleared contents.
- Arithmetic: `wr_count` saturates at 32767. `checksum` wraps modulo 2^22 (no wrap for ≤15876 writes).

## Timing
- Reset values: `load_ready`, `gray_ready`, `gray_data`, `rd_data`, `wr_count`, `checksum`, `err_border`, `err_dup`, `done` and `pass` all 0. The FSM is in CLEAR with index 0.
- Reset release to `load_ready` high: 16384 cycles.
- Final load handshake at edge N: `load_ready` falls and `gray_ready` rises in the cycle after N.
- `gray_data` has zero latency relative to `gray_addr`/`gray_req`.
- Result write: the memory, counter and flags update at the edge where `lbp_valid` is sampled. They are visible on outputs the next cycle, and on `rd_data` one more cycle later.
- `finish` sampled high at edge N: `done` is high from the cycle after N, and `gray_ready` falls in the same cycle.
- `restart` at edge N: `done` is 0 after N, and CLEAR restarts from index 0.

## Test plan
- Reset, then hold `load_valid`: `load_ready` rises exactly 16384 cycles after reset release. Load 16384 bytes with value (addr mod 251): `gray_ready` rises the cycle after the last handshake.
- SERVE, `gray_req=1`, `gray_addr`=0x0081 then 0x3FFF: `gray_data`=(0x81 mod 251)=129, then 16383 mod 251=68, in the same cycles. With `gray_req=0`: 0.
- Write 15876 interior results with `lbp_data`=0x5A, the last one coincident with `finish`: `wr_count`=15876, `checksum`=1428840, `done=1`, `pass=1`, and `rd_addr`=0x0081 gives 0x5A one cycle later.
- Write to 0x0000, then write 0x0101 twice: `err_border=1`, `err_dup=1`, `wr_count`=3. After `finish`: `pass=0`.
- Drive `reset` low mid-LOAD at k=5000: all outputs return to 0 and CLEAR is repeated in full. Likewise, `restart` in DONE re-enters CLEAR and `rd_data`=0 at 0x0081 after CLEAR.
